collision_arbiter: RTL



---
 rtl/collision_arbiter_if.sv | 34 +++
 rtl/collision_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/collision_arbiter_if.sv
// Pixel drawing-request bundle into the collision arbiter and the game
// events it produces. master = drawing blocks/controller side, slave = arbiter.
interface collision_arbiter_if #(
    parameter int LIVES_WIDTH      = 3,
    parameter int KILL_COUNT_WIDTH = 8
);
    logic                        startOfFrame;
    logic                        playerDR;
    logic                        playerMissileDR;
    logic                        monsterDR;
    logic                        monsterMissileDR;
    logic                        borderDR;
    logic [4:0]                  collision;
    logic                        player_hit_pulse;
    logic                        monster_kill_pulse;
    logic [KILL_COUNT_WIDTH-1:0] kill_frames;
    logic [LIVES_WIDTH-1:0]      lives;
    logic                        player_invulnerable;
    logic                        game_over;

    modport master (
        output startOfFrame, playerDR, playerMissileDR,
        output monsterDR, monsterMissileDR, borderDR,
        input  collision, player_hit_pulse, monster_kill_pulse,
        input  kill_frames, lives, player_invulnerable, game_over
    );

    modport slave (
        input  startOfFrame, playerDR, playerMissileDR,
        input  monsterDR, monsterMissileDR, borderDR,
        output collision, player_hit_pulse, monster_kill_pulse,
        output kill_frames, lives, player_invulnerable, game_over
    );
endinterface

// File: rtl/collision_arbiter.sv
// Collision arbiter: pixel collision vector, frame-aligned life loss,
// lives / invulnerability / game-over tracking and monster-kill counting.
// Ports: clk, resetN (async active-low), bus (collision_arbiter_if.slave):
//   DR inputs + startOfFrame in; collision, pulses, counters, flags out.
// Option: PLAYER_GOD_MODE_EN keeps hits/invulnerability but never costs lives.
module collision_arbiter #(
    parameter int INITIAL_LIVES    = 3,
    parameter int LIVES_WIDTH      = 3,
    parameter int INVULN_FRAMES    = 60,
    parameter int KILL_COUNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                resetN,
    collision_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    state_t                      state_q, state_d;
    logic [LIVES_WIDTH-1:0]      lives_q, lives_d;
    logic [7:0]                  inv_q, inv_d;
    logic [KILL_COUNT_WIDTH-1:0] kf_q, kf_d;
    logic                        hit_q, hit_d;
    logic                        kill_q, kill_d;
    logic                        hit_pulse, kill_pulse;
    logic [4:0]                  col;

    // Zero-latency so consumers can gate with their own squareDR.
    assign col[0] = bus.playerMissileDR  & bus.monsterDR;
    assign col[1] = bus.monsterDR        & bus.borderDR;
    assign col[2] = bus.monsterMissileDR & bus.playerDR;
    assign col[3] = bus.playerDR         & bus.borderDR;
    assign col[4] = bus.monsterMissileDR & bus.borderDR;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        inv_d      = inv_q;
        kf_d       = kf_q;
        hit_pulse  = 1'b0;
        kill_pulse = 1'b0;
        hit_d      = hit_q | col[2];
        kill_d     = kill_q | col[0];
        if (bus.startOfFrame) begin
            // The startOfFrame pixel already belongs to the new frame.
            hit_d      = col[2];
            kill_d     = col[0];
            kill_pulse = kill_q;
            if (kill_q && (kf_q != '1))
                kf_d = kf_q + KILL_COUNT_WIDTH'(1);
            unique case (state_q)
                ALIVE: begin
                    if (hit_q) begin
                        hit_pulse = 1'b1;
`ifdef PLAYER_GOD_MODE_EN
                        inv_d   = 8'(INVULN_FRAMES);
                        state_d = INVULN;
`else
                        if (lives_q > LIVES_WIDTH'(1)) begin
                            lives_d = lives_q - LIVES_WIDTH'(1);
                            inv_d   = 8'(INVULN_FRAMES);
                            state_d = INVULN;
                        end else begin
                            lives_d = '0;
                            state_d = DEAD;
                        end
`endif
                    end
                end
                INVULN: begin
                    if (inv_q <= 8'd1) begin
                        inv_d   = 8'd0;
                        state_d = ALIVE;
                    end else begin
                        inv_d = inv_q - 8'd1;
                    end
                end
                DEAD: begin
                end
                default: state_d = ALIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ALIVE;
            lives_q <= LIVES_WIDTH'(INITIAL_LIVES);
            inv_q   <= 8'd0;
            kf_q    <= '0;
            hit_q   <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            inv_q   <= inv_d;
            kf_q    <= kf_d;
            hit_q   <= hit_d;
            kill_q  <= kill_d;
        end
    end

    assign bus.collision           = col;
    assign bus.player_hit_pulse    = hit_pulse;
    assign bus.monster_kill_pulse  = kill_pulse;
    assign bus.kill_frames         = kf_q;
    assign bus.lives               = lives_q;
    assign bus.player_invulnerable = (state_q == INVULN);
    assign bus.game_over           = (state_q == DEAD);
endmodule
